uart_rx_parity: RTL

- Serial UART receiver; the receive-side counterpart of the transmit-path parity generator.
- Deserialises 8N1, 8O1 and 8E1 frames from an asynchronous rx line.
- Checks the optional parity bit and the stop bit.
- Presents a byte with valid and error flags to the downstream consumer (display/control logic).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx_parity.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the parity-mode codes
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // 2'b11 is treated as "no parity", same as PAR_NONE.
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; both flops load
// RST_VAL during reset so the output never glitches out of reset.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver for 8N1 / 8O1 / 8E1 frames with parity and stop-bit checking.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line idle, waiting for rx_s low (start bit edge)
//   START  | wait to start-bit midpoint, reject glitches
//   DATA   | sample 8 data bits, LSB first, one per bit period
//   PARITY | sample parity bit and compare with expected value
//   STOP   | sample stop bit, publish byte and error flags
//   BREAK  | stop bit was low; wait for line to return high
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [1:0] parity_type,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [1:0]       par_mode;
    logic             perr;

    logic             cnt_half;
    logic             cnt_last;
    logic             start_det;
    logic             start_ok;
    logic             data_smp;
    logic             par_smp;
    logic             stop_smp;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign cnt_half = (cnt == CNT_HALF);
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        start_ok  = 1'b0;
        data_smp  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (cnt_half) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        start_ok  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt_last) begin
                    data_smp = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = parity_on(par_mode) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    stop_smp  = 1'b1;
                    state_nxt = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // After the start midpoint the counter wraps every bit period, so each
    // terminal count lands on the middle of the following bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            case (state)
                START:               cnt <= cnt_half ? '0 : cnt + CNT_W'(1);
                DATA, PARITY, STOP:  cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
                default:             cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            par_mode <= PAR_NONE;
            perr     <= 1'b0;
        end else begin
            if (start_det) begin
                par_mode <= parity_type;
                perr     <= 1'b0;
            end
            if (start_ok) begin
                bit_idx <= 3'd0;
            end else if (data_smp && bit_idx != 3'd7) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (data_smp) begin
                shift[bit_idx] <= rx_s;
            end
            // Must match the transmitter: odd -> ~^data, even -> ^data.
            if (par_smp) begin
                perr <= rx_s != ((par_mode == PAR_ODD) ? ~^shift : ^shift);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= stop_smp;
            if (stop_smp) begin
                dout       <= shift;
                frame_err  <= ~rx_s;
                parity_err <= parity_on(par_mode) ? perr : 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
